// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, half-bit centred sampling, one-entry holding register
// with valid/ready handshake and framing-error/overrun pulses.
module uart_rx #(
  parameter int CLK_FREQ     = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic rxd_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, fe_q, fe_d, ov_q, ov_d;
  assign rxd_s = sync_q[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], serial_rxd};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    unique case (state_q)
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d       = '0;
        sh_d[idx_q] = rxd_s;
        idx_d       = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (cnt_q == FULL) begin
        cnt_d = '0;
        // a full register not drained this cycle keeps its byte; the new one is dropped
        if (!rxd_s) begin
          fe_d    = 1'b1;
          state_d = WAIT_IDLE;
        end else begin
          state_d = IDLE;
          if (valid_q && !rx_ready) ov_d = 1'b1;
          else begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = state_q != IDLE;
endmodule
